regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised architectural register file for the pipelined CPU, replacing the fixed 2-read/1-write file. It has NUM_RD read ports and one writeback port with same-cycle write-to-read bypass. A per-register pending-write scoreboard lets decode detect RAW hazards on in-flight producers. Sits between decode (issue/read) and writeback.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = index 0 hardwired to zero and never pending; 0 = index 0 is an ordinary register

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port k's register has an outstanding producer not satisfied this cycle
iss_en  in  1  decode issues an instruction writing iss_addr; mark pending
iss_addr  in  ADDR_W  destination of issuing instruction
wb_en  in  1  writeback valid
wb_addr  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback value
flush  in  1  pipeline flush; clear all pending bits
pend_cnt  out  ADDR_W+1  number of registers currently marked pending

Behaviour:
- Reset: while rst_n=0 at a rising edge, all registers <= 0, all pending bits <= 0, pend_cnt <= 0; reset overrides wb_en, iss_en, flush in that cycle. Combinational outputs then read 0 / rd_busy=0.
- Storage: 2**ADDR_W x DATA_W flops, written on rising edge (not falling edge as in previous generation); write when wb_en=1 and not (ZERO_REG=1 and wb_addr=0).
- Read (combinational, zero latency), per port k with address a:
  - ZERO_REG=1 and a=0 -> rd_data=0, rd_busy=0.
  - else wb_en=1 and wb_addr=a -> rd_data=wb_data (bypass), rd_busy=0.
  - else rd_data=reg[a], rd_busy=pending[a].
- Ports are fully independent; same address on several ports returns identical results.
- Pending update at rising edge, priority high to low: reset; then per bit i: set if iss_en and iss_addr=i; else clear if flush; else clear if wb_en and wb_addr=i; else hold.
  - iss and wb same index same cycle -> bit stays/becomes 1 (newer producer outstanding); data still written.
  - flush with iss same cycle -> only iss_addr pending afterwards.
  - flush with wb -> data written, all other bits cleared.
  - iss to an already-pending register -> stays 1 (single-bit, no count per register).
  - ZERO_REG=1: index 0 never set.
- pend_cnt: registered population count of pending bits, updated same edge as bits; equals popcount at all times; max 2**ADDR_W, no wrap.
- Writeback to non-pending register is legal: data written, bit unchanged (0).
- No X propagation: uninitialised state impossible after first reset edge.

Test Plan:
- Reset: drive rst_n=0 one edge with wb_en=1,wb_addr=3,wb_data=0xDEADBEEF -> after edge reg3 reads 0, pend_cnt=0, rd_busy=0.
- Write/read: wb r5=0x12345678, next cycle rd_addr port0=5, port1=5 -> both rd_data=0x12345678, rd_busy=00.
- Bypass: reg7=0x11; same cycle wb_en r7=0x22 and rd_addr port1=7 -> rd_data port1=0x22, rd_busy[1]=0; next cycle reads 0x22.
- Scoreboard: iss r9 -> next cycle port0 reads r9 rd_busy[0]=1, pend_cnt=1; wb r9=0xAA -> same cycle busy=0, data 0xAA; next cycle pend_cnt=0.
- Zero reg: wb r0=0xFFFFFFFF, iss r0 -> r0 reads 0, busy 0, pend_cnt unchanged; ZERO_REG=0 build -> r0 reads 0xFFFFFFFF.
- Simultaneous: pending r4,r6; same edge flush=1, iss r6, wb r4=0x5 -> after edge pending only r6, pend_cnt=1, r4 reads 0x5 not busy.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, issue, writeback.
// master = pipeline side (drives indices/writeback), slave = register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output rd_addr, iss_en, iss_addr,
        output wb_en, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, iss_en, iss_addr,
        input  wb_en, wb_addr, wb_data, flush,
        output rd_data, rd_busy, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD read ports, write-to-read bypass and a
// pending-write scoreboard. Ports: clk, rst_n (sync, active-low), bus (slave).
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic                clk,
    input logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en;

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]        ra;

    assign wr_en = bus.wb_en &&
                   !(ZERO_REG != 0 && bus.wb_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // A new issue wins over flush and writeback so a younger producer
    // to the same register stays tracked.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.iss_en && bus.iss_addr == ADDR_W'(i)) begin
                pend_d[i] = 1'b1;
            end else if (bus.flush) begin
                pend_d[i] = 1'b0;
            end else if (bus.wb_en && bus.wb_addr == ADDR_W'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
                rd_busy_c[k]                  = 1'b0;
            end else if (bus.wb_en && bus.wb_addr == ra) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.wb_data;
                rd_busy_c[k]                  = 1'b0;
            end else begin
                rd_data_c[k*DATA_W +: DATA_W] = regs_q[ra];
                rd_busy_c[k]                  = pend_q[ra];
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (ZERO_REG=1 and ZERO_REG=0 builds).
// Both instances see identical stimulus; expected values are hand-computed.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                         .ZERO_REG(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                         .ZERO_REG(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    assign bus0.rd_addr  = bus.rd_addr;
    assign bus0.iss_en   = bus.iss_en;
    assign bus0.iss_addr = bus.iss_addr;
    assign bus0.wb_en    = bus.wb_en;
    assign bus0.wb_addr  = bus.wb_addr;
    assign bus0.wb_data  = bus.wb_data;
    assign bus0.flush    = bus.flush;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [31:0] rd(input logic [63:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    initial begin
        idle();
        bus.rd_addr = '0;
        rst_n       = 1'b0;
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'hDEADBEEF;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd3;
        step();
        rst_n = 1'b1;
        idle();
        bus.rd_addr = {5'd3, 5'd3};
        #1;
        check("rst_rd0", rd(bus.rd_data, 0), 32'h0);
        check("rst_busy", {30'd0, bus.rd_busy}, 32'h0);
        check("rst_cnt", {26'd0, bus.pend_cnt}, 32'h0);

        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h12345678;
        step();
        idle();
        bus.rd_addr = {5'd5, 5'd5};
        #1;
        check("wr_rd0", rd(bus.rd_data, 0), 32'h12345678);
        check("wr_rd1", rd(bus.rd_data, 1), 32'h12345678);
        check("wr_busy", {30'd0, bus.rd_busy}, 32'h0);

        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h11;
        step();
        bus.wb_data = 32'h22;
        bus.rd_addr = {5'd7, 5'd5};
        #1;
        check("byp_rd1", rd(bus.rd_data, 1), 32'h22);
        check("byp_busy1", {31'd0, bus.rd_busy[1]}, 32'h0);
        check("byp_rd0", rd(bus.rd_data, 0), 32'h12345678);
        step();
        idle();
        #1;
        check("byp_after", rd(bus.rd_data, 1), 32'h22);

        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd9;
        step();
        idle();
        bus.rd_addr = {5'd5, 5'd9};
        #1;
        check("sb_busy", {31'd0, bus.rd_busy[0]}, 32'h1);
        check("sb_cnt", {26'd0, bus.pend_cnt}, 32'h1);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'hAA;
        #1;
        check("sb_wb_busy", {31'd0, bus.rd_busy[0]}, 32'h0);
        check("sb_wb_data", rd(bus.rd_data, 0), 32'hAA);
        check("sb_wb_cnt", {26'd0, bus.pend_cnt}, 32'h1);
        step();
        idle();
        #1;
        check("sb_cnt0", {26'd0, bus.pend_cnt}, 32'h0);
        check("sb_rd_aa", rd(bus.rd_data, 0), 32'hAA);
        check("sb_busy0", {31'd0, bus.rd_busy[0]}, 32'h0);

        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'hFFFFFFFF;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd0;
        bus.rd_addr  = {5'd5, 5'd0};
        #1;
        check("z_byp_rd", rd(bus.rd_data, 0), 32'h0);
        check("z0_byp_rd", rd(bus0.rd_data, 0), 32'hFFFFFFFF);
        step();
        idle();
        #1;
        check("z_rd", rd(bus.rd_data, 0), 32'h0);
        check("z_busy", {31'd0, bus.rd_busy[0]}, 32'h0);
        check("z_cnt", {26'd0, bus.pend_cnt}, 32'h0);
        check("z0_rd", rd(bus0.rd_data, 0), 32'hFFFFFFFF);
        check("z0_busy", {31'd0, bus0.rd_busy[0]}, 32'h1);
        check("z0_cnt", {26'd0, bus0.pend_cnt}, 32'h1);

        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd4;
        step();
        bus.iss_addr = 5'd6;
        step();
        idle();
        #1;
        check("sim_cnt2", {26'd0, bus.pend_cnt}, 32'h2);
        check("sim0_cnt3", {26'd0, bus0.pend_cnt}, 32'h3);
        bus.flush    = 1'b1;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd6;
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd4;
        bus.wb_data  = 32'h5;
        step();
        idle();
        bus.rd_addr = {5'd6, 5'd4};
        #1;
        check("sim_cnt1", {26'd0, bus.pend_cnt}, 32'h1);
        check("sim_busy", {30'd0, bus.rd_busy}, 32'h2);
        check("sim_rd4", rd(bus.rd_data, 0), 32'h5);
        check("sim0_cnt1", {26'd0, bus0.pend_cnt}, 32'h1);

        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd6;
        step();
        idle();
        #1;
        check("repend_cnt", {26'd0, bus.pend_cnt}, 32'h1);
        check("repend_busy", {30'd0, bus.rd_busy}, 32'h2);

        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd10;
        bus.wb_data = 32'hCAFE;
        step();
        idle();
        bus.rd_addr = {5'd10, 5'd10};
        #1;
        check("np_rd", rd(bus.rd_data, 1), 32'hCAFE);
        check("np_busy", {30'd0, bus.rd_busy}, 32'h0);
        check("np_cnt", {26'd0, bus.pend_cnt}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
